// File: rtl/mem_pkg.sv
// Shared state encoding and constants for the two-bank burst memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int DEF_DEPTH_WORDS = 64;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_WAIT_ST     = 1;
  localparam int DEF_LEN_W       = 4;

  localparam int WORD_STEP = 2;
  localparam int BYTE_STEP = 1;

endpackage

// File: rtl/mem_bank.sv
// 8-bit single-port synchronous RAM bank, read-before-write.
// Latency: dout_o valid one cycle after addr_i; writes commit on the same edge.
// Backpressure: none, always accepts.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o
);

  logic [7:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller over an even/odd byte-banked RAM with word and byte beats.
// Latency: single read returns WAIT_ST+2 cycles after accept; writes ack at WAIT_ST+1.
// Backpressure: req_ready only in IDLE; requests offered while busy are dropped.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_ST     = DEF_WAIT_ST,
  parameter int LEN_W       = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [15:0]       req_wdata,
  output logic              beat_ack,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic              err
);

  localparam int               BANK_AW    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_L   = ADDR_W'(DEPTH_WORDS);
  localparam logic [3:0]       WAIT_LAST  = (WAIT_ST == 0) ? 4'd0 : 4'(WAIT_ST - 1);
  localparam state_t           BEAT_ENTRY = (WAIT_ST == 0) ? ST_ACCESS : ST_WAIT;

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [15:0]         rdata_q, rdata_d;

  logic                we_even, we_odd;
  logic [7:0]          din_odd;
  logic [7:0]          even_dout, odd_dout;
  logic [7:0]          sel_byte;
  logic [15:0]         rd_fmt;
  logic                beat_ok, last_beat, advance;
  logic [ADDR_W-1:0]   addr_step;

  // A beat is legal only if word-aligned (for word mode) and inside the array.
  assign beat_ok   = !(!byte_q && addr_q[0]) && ({1'b0, addr_q[ADDR_W-1:1]} < DEPTH_L);
  assign last_beat = (rem_q == '0);
  assign addr_step = byte_q ? ADDR_W'(BYTE_STEP) : ADDR_W'(WORD_STEP);
  assign din_odd   = byte_q ? req_wdata[7:0] : req_wdata[15:8];
  assign sel_byte  = addr_q[0] ? odd_dout : even_dout;
  assign rd_fmt    = byte_q ? {{8{sel_byte[7]}}, sel_byte} : {odd_dout, even_dout};
  assign busy      = (state_q != ST_IDLE);

  mem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(BANK_AW)) u_even (
    .clk    (clk),
    .we_i   (we_even),
    .addr_i (addr_q[BANK_AW:1]),
    .din_i  (req_wdata[7:0]),
    .dout_o (even_dout)
  );

  mem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(BANK_AW)) u_odd (
    .clk    (clk),
    .we_i   (we_odd),
    .addr_i (addr_q[BANK_AW:1]),
    .din_i  (din_odd),
    .dout_o (odd_dout)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    byte_d     = byte_q;
    rem_d      = rem_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    beat_ack   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    rsp_rdata  = rdata_q;
    err        = 1'b0;
    we_even    = 1'b0;
    we_odd     = 1'b0;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && req_ready) begin
          addr_d     = req_addr;
          write_d    = req_write;
          byte_d     = req_byte;
          rem_d      = (req_len == '0) ? '0 : req_len - LEN_W'(1);
          wait_cnt_d = 4'd0;
          state_d    = BEAT_ENTRY;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = 4'd0;
          state_d    = ST_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_ACCESS: begin
        if (!beat_ok) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          beat_ack = 1'b1;
          if (write_q) begin
            we_even  = !byte_q || !addr_q[0];
            we_odd   = !byte_q ||  addr_q[0];
            rsp_last = last_beat;
            advance  = 1'b1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rd_fmt;
        rsp_last  = last_beat;
        rdata_d   = rd_fmt;
        advance   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Address and beat count move only when a beat has fully completed.
    if (advance) begin
      addr_d  = addr_q + addr_step;
      rem_d   = rem_q - LEN_W'(1);
      state_d = last_beat ? ST_IDLE : BEAT_ENTRY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      rem_q      <= '0;
      rdata_q    <= 16'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      byte_q     <= byte_d;
      rem_q      <= rem_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, meaning number of 16-bit words, power of two, 4..65536.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width; must satisfy 2**(ADDR_W-1) >= DEPTH_WORDS.
REQ-003 The block SHALL have parameter WAIT_ST, default 1, meaning wait states inserted before every beat, range 0..15.
REQ-004 The block SHALL have parameter LEN_W, default 4, meaning width of burst-length field.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: port clk (input, 1, all logic on posedge) and port rst (input, 1, asynchronous active-high reset).
REQ-006 The block SHALL have the following request ports:
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_write, input, 1: 1 = write, 0 = read.
- req_byte, input, 1: 1 = byte mode, 0 = word mode.
- req_addr, input, ADDR_W: start byte address.
- req_len, input, LEN_W: beat count; 0 means 1.
- req_wdata, input, 16: write data, sampled per write beat.
REQ-007 The block SHALL have the following response and status ports:
- beat_ack, output, 1: pulses in the ACCESS cycle of each completed beat.
- rsp_valid, output, 1: read data valid, one cycle per read beat.
- rsp_rdata, output, 16: read data.
- rsp_last, output, 1: qualifies the final beat (with beat_ack for writes, with rsp_valid for reads).
- busy, output, 1: state != IDLE.
- err, output, 1: one-cycle pulse on an aborted beat.

Function
REQ-010 Storage SHALL be two 8-bit banks of DEPTH_WORDS entries: even bank holds byte address bit0=0 and word bits [7:0]; odd bank holds bit0=1 and word bits [15:8].
REQ-011 The FSM SHALL use states IDLE, WAIT, ACCESS and RESP.
REQ-012 The FSM SHALL move from IDLE to WAIT (WAIT_ST>0) or to ACCESS (WAIT_ST=0) on req_valid&&req_ready, latching addr, write, byte and len.
REQ-013 WAIT SHALL last exactly WAIT_ST cycles, counted by wait_cnt, then go to ACCESS.
REQ-014 ACCESS SHALL last one cycle; the RAM write commits at its closing edge, and reads are issued in it.
REQ-015 After ACCESS, a read beat SHALL go to RESP (1 cycle, rsp_valid=1); a write beat SHALL skip RESP.
REQ-016 After each beat, the FSM SHALL go to WAIT/ACCESS if beats remain, else to IDLE.
REQ-017 req_ready SHALL be 1 only in IDLE; requests presented while busy are ignored, not queued.
REQ-018 Single-read latency SHALL be: accept edge at cycle 0, rsp_valid at cycle WAIT_ST+2.
REQ-019 Write data SHALL be taken from req_wdata in each ACCESS cycle; the source must hold the current beat's data until beat_ack.
REQ-020 A word write SHALL write both banks; a byte write SHALL write only the bank selected by addr[0], with wdata[7:0].
REQ-021 A word read SHALL return {odd,even}; a byte read SHALL return the selected byte sign-extended to 16 bits.
REQ-022 The beat address SHALL advance by 2 after each word beat and by 1 after each byte beat.
REQ-023 A word beat with addr[0]=1 SHALL be misaligned: no bank access, err=1 in that ACCESS cycle, no beat_ack/rsp_valid, and the burst aborts to IDLE.
REQ-024 A beat with word index addr[ADDR_W-1:1] >= DEPTH_WORDS SHALL be handled the same as REQ-023; bursts never wrap.
REQ-025 rsp_rdata SHALL hold its last value outside RESP.
REQ-026 rsp_last SHALL be asserted only on the final beat.

Reset
REQ-030 rst assertion SHALL, at any state including mid-burst, force IDLE and clear wait_cnt, beat counter and latched request.
REQ-031 While rst is asserted, all outputs SHALL be 0, including req_ready and rsp_rdata.
REQ-032 Bank contents SHALL NOT be reset.
REQ-033 An interrupted burst SHALL leave committed beats written and uncommitted beats unwritten.

Structure
REQ-040 Package mem_pkg SHALL hold the state enum, the default parameter constants and the beat-step constants (WORD_STEP=2, BYTE_STEP=1).
REQ-041 Sub-module mem_bank SHALL be an 8-bit, DEPTH_WORDS-entry synchronous RAM (posedge clk, we, addr, din, registered dout), instantiated twice.

Verification
REQ-050 With WAIT_ST=1, a single word write of 0xA55A to address 0x0004, then a word read of 0x0004, SHALL give rsp_valid at cycle 3 after accept and rsp_rdata=0xA55A with rsp_last=1.
REQ-051 A byte write of 0x80 to 0x0005, then a byte read of 0x0005 SHALL return 0xFF80; a word read of 0x0004 SHALL then return 0x805A.
REQ-052 A write burst of len=4 from 0x0010 with data 1,2,3,4, then a read burst of len=4, SHALL give four rsp_valid pulses returning 1,2,3,4, with rsp_last on the 4th only; req_ready SHALL stay 0 throughout.
REQ-053 A word read at 0x0003 SHALL give err=1 for one cycle with no rsp_valid and return to IDLE; a read burst len=3 from word 62 (DEPTH 64) SHALL return 2 beats, then err on the 3rd.
REQ-054 rst asserted during the WAIT of beat 3 of a write burst len=4 SHALL force immediate IDLE with outputs 0; beats 1-2 read back written and beats 3-4 hold their old values.
REQ-055 With WAIT_ST=0, a single read SHALL give rsp_valid at cycle 2 after accept.
